// File: rtl/rcon_lfsr_gen_pkg.sv
// Shared types and LFSR arithmetic for the round-constant generator.
// Values are carried in a fixed MAXW-bit word and masked to the active width w,
// so one set of functions serves every instance width.
package rcon_pkg;

  localparam int unsigned MAXW = 32;

  typedef logic [MAXW-1:0] lfsr_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Low w bits set.
  function automatic lfsr_word_t width_mask(input int unsigned w);
    lfsr_word_t m;
    if (w >= MAXW) m = '1;
    else           m = (lfsr_word_t'(1) << w) - lfsr_word_t'(1);
    return m;
  endfunction

  // Multiply by x modulo (x^w + poly).
  function automatic lfsr_word_t lfsr_fwd(input lfsr_word_t c, input lfsr_word_t poly,
                                          input int unsigned w);
    lfsr_word_t msk;
    lfsr_word_t top;
    lfsr_word_t r;
    msk = width_mask(w);
    top = lfsr_word_t'(1) << (w - 1);
    r   = (c << 1) & msk;
    if ((c & top) != '0) r = r ^ (poly & msk);
    return r;
  endfunction

  // Divide by x modulo (x^w + poly); relies on poly[0] = 1 to be the exact inverse.
  function automatic lfsr_word_t lfsr_inv(input lfsr_word_t c, input lfsr_word_t poly,
                                          input int unsigned w);
    lfsr_word_t msk;
    lfsr_word_t top;
    lfsr_word_t cm;
    lfsr_word_t r;
    msk = width_mask(w);
    top = lfsr_word_t'(1) << (w - 1);
    cm  = c & msk;
    if (cm[0]) r = ((cm ^ (poly & msk)) >> 1) | top;
    else       r = cm >> 1;
    return r;
  endfunction

  // seed * x^n, evaluated at elaboration to find the last constant of a run.
  function automatic lfsr_word_t lfsr_jump(input lfsr_word_t seed, input lfsr_word_t poly,
                                           input int unsigned w, input int unsigned n);
    lfsr_word_t r;
    r = seed;
    for (int unsigned k = 0; k < n; k++) r = lfsr_fwd(r, poly, w);
    return r;
  endfunction

endpackage

// File: rtl/rcon_lfsr_gen_if.sv
// Control and constant-stream bundle between the generator and its consumer.
interface rcon_lfsr_gen_if #(
  parameter int unsigned W     = 7,
  parameter int unsigned LANES = 4
) ();

  logic                 start;
  logic                 dir;
  logic [LANES*W-1:0]   rc;
  logic                 rc_valid;
  logic                 rc_ready;
  logic                 rc_last;
  logic                 busy;
  logic                 done;

  // Generator side.
  modport master (
    input  start, dir, rc_ready,
    output rc, rc_valid, rc_last, busy, done
  );

  // Consumer / controller side.
  modport slave (
    output start, dir, rc_ready,
    input  rc, rc_valid, rc_last, busy, done
  );

endinterface

// File: rtl/rcon_lfsr_gen_step.sv
// One combinational LFSR step in either direction; chained to build the lanes.
module rcon_step
  import rcon_pkg::*;
#(
  parameter int unsigned  W    = 7,
  parameter logic [W-1:0] POLY = 'h03
) (
  input  logic [W-1:0] c_i,
  input  logic         dir_i,
  output logic [W-1:0] nxt_o
);

  lfsr_word_t fwd_w;
  lfsr_word_t inv_w;

  // Evaluate both directions and pick the latched one.
  always_comb begin
    fwd_w = lfsr_fwd(lfsr_word_t'(c_i), lfsr_word_t'(POLY), W);
    inv_w = lfsr_inv(lfsr_word_t'(c_i), lfsr_word_t'(POLY), W);
    nxt_o = dir_i ? W'(inv_w) : W'(fwd_w);
  end

endmodule

// File: rtl/rcon_lfsr_gen.sv
// Round-constant generator: LANES constants per beat from a W-bit Galois LFSR,
// NCONST constants per run, forward or reversed, over a valid/ready stream.
module rcon_lfsr_gen
  import rcon_pkg::*;
#(
  parameter int unsigned  W      = 7,
  parameter logic [W-1:0] POLY   = 'h03,
  parameter logic [W-1:0] SEED   = 'h01,
  parameter int unsigned  LANES  = 4,
  parameter int unsigned  NCONST = 40
) (
  input logic              clk,
  input logic              rst,
  rcon_lfsr_gen_if.master  bus
);

  localparam int unsigned  NBEATS   = NCONST / LANES;
  localparam int unsigned  CW       = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NBEATS - 1);
  // Value of constant index NCONST-1: starting point of an inverse run.
  localparam logic [W-1:0] END_C    =
    W'(lfsr_jump(lfsr_word_t'(SEED), lfsr_word_t'(POLY), W, NCONST - 1));

  // Reject parameter sets that would give a non-invertible or ragged sequence.
  if (W < 2 || W > MAXW) begin : g_bad_w
    $fatal(1, "rcon_lfsr_gen: W out of range");
  end
  if (!POLY[0]) begin : g_bad_poly
    $fatal(1, "rcon_lfsr_gen: POLY[0] must be 1");
  end
  if (SEED == '0) begin : g_bad_seed
    $fatal(1, "rcon_lfsr_gen: SEED must be nonzero");
  end
  if (LANES < 1 || NCONST < 1 || (NCONST % LANES) != 0) begin : g_bad_lanes
    $fatal(1, "rcon_lfsr_gen: NCONST must be a nonzero multiple of LANES");
  end

  state_e          state_q, state_d;
  logic [W-1:0]    s_q, s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            done_q, done_d;

  logic            busy;
  logic            fire;
  logic            last;
  logic [W-1:0]    chain [0:LANES];
  logic [LANES*W-1:0] lanes_flat;

  // Lane j is j steps from s; the step after the last lane is the next s.
  assign chain[0] = s_q;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      rcon_step #(
        .W    (W),
        .POLY (POLY)
      ) u_step (
        .c_i   (chain[gi]),
        .dir_i (dir_q),
        .nxt_o (chain[gi+1])
      );
      assign lanes_flat[gi*W +: W] = chain[gi];
    end
  endgenerate

  assign busy         = (state_q == RUN);
  assign fire         = busy & bus.rc_ready;
  assign last         = busy & (cnt_q == LAST_CNT);

  assign bus.rc_valid = busy;
  assign bus.rc       = busy ? lanes_flat : '0;
  assign bus.rc_last  = last;
  assign bus.busy     = busy;
  assign bus.done     = done_q;

  // Next-state: accept start in IDLE, advance on each handshake, leave after the last beat.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          dir_d   = bus.dir;
          cnt_d   = '0;
          s_d     = bus.dir ? END_C : SEED;
        end
      end
      RUN: begin
        if (fire) begin
          s_d = chain[LANES];
          if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= SEED;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_rcon_lfsr_gen.sv
// Directed bench for rcon_lfsr_gen: default configuration plus a W=8 lane sweep.
module tb_rcon_lfsr_gen;

  localparam int W      = 7;
  localparam int LANES  = 4;
  localparam int NCONST = 40;
  localparam int NBEATS = NCONST / LANES;
  localparam int SW_W   = 8;
  localparam int SW_N   = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sweep_go = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  int unsigned  seq7 [NCONST];
  int unsigned  seq8 [SW_N];
  logic [63:0]  hand_fwd [3];

  always #5 clk = ~clk;

  rcon_lfsr_gen_if #(.W(W), .LANES(LANES)) bus ();

  rcon_lfsr_gen #(
    .W      (W),
    .POLY   (7'h03),
    .SEED   (7'h01),
    .LANES  (LANES),
    .NCONST (NCONST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Polynomial view: shift left, reduce by x^w + poly when degree w appears.
  function automatic int unsigned mdl_step(input int unsigned v, input int unsigned poly,
                                           input int w);
    int unsigned t;
    t = v << 1;
    if ((t >> w) != 0) t = t ^ ((32'd1 << w) | poly);
    return t;
  endfunction

  function automatic logic [63:0] pack4(input logic [6:0] a, input logic [6:0] b,
                                        input logic [6:0] c, input logic [6:0] d);
    return {36'd0, d, c, b, a};
  endfunction

  function automatic logic [63:0] exp_beat(input int b, input bit d);
    logic [63:0] v;
    int idx;
    v = '0;
    for (int j = 0; j < LANES; j++) begin
      idx = d ? (NCONST - 1 - (b * LANES + j)) : (b * LANES + j);
      v[j*W +: W] = 7'(seq7[idx]);
    end
    return v;
  endfunction

  task automatic do_run(input bit d, input int bp_beat, input int bp_cyc,
                        input int pulse_beat, input string nm);
    logic [63:0] ev;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dir   = ~d;
    for (int b = 0; b < NBEATS; b++) begin
      @(negedge clk);
      ev = exp_beat(b, d);
      check_val($sformatf("%s_rc_b%0d", nm, b), 64'(bus.rc), ev);
      check_val($sformatf("%s_valid_b%0d", nm, b), 64'(bus.rc_valid), 64'(1));
      check_val($sformatf("%s_last_b%0d", nm, b), 64'(bus.rc_last), 64'(b == NBEATS - 1));
      if (!d && b < 3)
        check_val($sformatf("%s_hand_b%0d", nm, b), 64'(bus.rc), hand_fwd[b]);
      if (d && b == NBEATS - 1)
        check_val($sformatf("%s_hand_b9", nm), 64'(bus.rc),
                  pack4(7'h08, 7'h04, 7'h02, 7'h01));
      if (b == bp_beat) begin
        bus.rc_ready = 1'b0;
        for (int k = 1; k <= bp_cyc; k++) begin
          @(negedge clk);
          check_val($sformatf("%s_hold_rc_%0d", nm, k), 64'(bus.rc), ev);
          check_val($sformatf("%s_hold_last_%0d", nm, k), 64'(bus.rc_last), 64'(0));
        end
        bus.rc_ready = 1'b1;
      end
      if (b == pulse_beat || b == NBEATS - 1) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    @(negedge clk);
    check_val({nm, "_done"}, 64'(bus.done), 64'(1));
    check_val({nm, "_done_busy"}, 64'(bus.busy), 64'(0));
    check_val({nm, "_done_valid"}, 64'(bus.rc_valid), 64'(0));
    check_val({nm, "_done_rc"}, 64'(bus.rc), 64'(0));
  endtask

  task automatic check_idle(input string nm);
    check_val({nm, "_rc"}, 64'(bus.rc), 64'(0));
    check_val({nm, "_valid"}, 64'(bus.rc_valid), 64'(0));
    check_val({nm, "_last"}, 64'(bus.rc_last), 64'(0));
    check_val({nm, "_busy"}, 64'(bus.busy), 64'(0));
    check_val({nm, "_done"}, 64'(bus.done), 64'(0));
  endtask

  // W=8, POLY=1D, NCONST=15 with 1, 3 and 5 lanes under random backpressure.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
      localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 3 : 5);
      logic fin = 1'b0;

      rcon_lfsr_gen_if #(.W(SW_W), .LANES(L)) sif ();

      rcon_lfsr_gen #(
        .W      (SW_W),
        .POLY   (8'h1D),
        .SEED   (8'h01),
        .LANES  (L),
        .NCONST (SW_N)
      ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
      );

      initial begin : sw_proc
        logic [7:0] got     [SW_N];
        logic [7:0] fwd_got [SW_N];
        int n;
        int cyc;
        sif.start    = 1'b0;
        sif.dir      = 1'b0;
        sif.rc_ready = 1'b0;
        wait (sweep_go);
        for (int pass = 0; pass < 2; pass++) begin
          for (int i = 0; i < SW_N; i++) got[i] = '0;
          @(posedge clk); #1;
          sif.start = 1'b1;
          sif.dir   = (pass == 1);
          @(posedge clk); #1;
          sif.start    = 1'b0;
          sif.rc_ready = ($urandom_range(0, 1) != 0);
          n   = 0;
          cyc = 0;
          while (n < SW_N && cyc < 400) begin
            @(negedge clk);
            if (sif.rc_valid && sif.rc_ready) begin
              for (int j = 0; j < L; j++) got[n + j] = sif.rc[j*SW_W +: SW_W];
              check_val($sformatf("sw%0d_p%0d_last_%0d", L, pass, n),
                        64'(sif.rc_last), 64'(n + L == SW_N));
              n += L;
            end
            @(posedge clk); #1;
            sif.rc_ready = ($urandom_range(0, 1) != 0);
            cyc++;
          end
          check_val($sformatf("sw%0d_p%0d_count", L, pass), 64'(n), 64'(SW_N));
          @(negedge clk);
          check_val($sformatf("sw%0d_p%0d_done", L, pass), 64'(sif.done), 64'(1));
          for (int i = 0; i < SW_N; i++) begin
            check_val($sformatf("sw%0d_p%0d_c%0d", L, pass, i), 64'(got[i]),
                      64'((pass == 1) ? seq8[SW_N - 1 - i] : seq8[i]));
            if (pass == 1)
              check_val($sformatf("sw%0d_rev_c%0d", L, i), 64'(got[i]),
                        64'(fwd_got[SW_N - 1 - i]));
          end
          if (pass == 0) for (int i = 0; i < SW_N; i++) fwd_got[i] = got[i];
        end
        fin = 1'b1;
      end
    end
  endgenerate

  initial begin
    seq7[0] = 32'h01;
    for (int i = 1; i < NCONST; i++) seq7[i] = mdl_step(seq7[i-1], 32'h03, W);
    seq8[0] = 32'h01;
    for (int i = 1; i < SW_N; i++) seq8[i] = mdl_step(seq8[i-1], 32'h1D, SW_W);
    hand_fwd[0] = pack4(7'h01, 7'h02, 7'h04, 7'h08);
    hand_fwd[1] = pack4(7'h10, 7'h20, 7'h40, 7'h03);
    hand_fwd[2] = pack4(7'h06, 7'h0C, 7'h18, 7'h30);

    bus.start    = 1'b0;
    bus.dir      = 1'b0;
    bus.rc_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Forward run, consumer always ready.
    bus.rc_ready = 1'b1;
    bus.start    = 1'b1;
    bus.dir      = 1'b0;
    do_run(1'b0, -1, 0, -1, "fwd");
    @(negedge clk);
    check_idle("fwd_after");

    // Inverse run with a stray start mid-run, then a start in the done cycle.
    bus.start = 1'b1;
    bus.dir   = 1'b1;
    do_run(1'b1, -1, 0, 5, "inv");
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    do_run(1'b0, 1, 3, -1, "bp");
    @(negedge clk);
    check_idle("bp_after");

    // Reset in the middle of a run.
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("rst_pre_b4", 64'(bus.rc), exp_beat(4, 1'b0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_mid");
    @(negedge clk);
    check_idle("rst_nodone");
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check_val("rst_restart_b0", 64'(bus.rc), hand_fwd[0]);
    check_val("rst_restart_valid", 64'(bus.rc_valid), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Parameter sweep runs in the generate blocks.
    sweep_go = 1'b1;
    for (int c = 0; c < 5000 && !(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin); c++)
      @(posedge clk);
    check_val("sweep_finished", 64'({g_sw[0].fin, g_sw[1].fin, g_sw[2].fin}), 64'(3'b111));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rcon_lfsr_gen.md
# rcon_lfsr_gen

Parametrised round-constant generator for the cipher datapath. It produces LANES constants per beat from a W-bit Galois LFSR: constant i is SEED·x^i in GF(2)[x]/(x^W + POLY). The sequence runs forward for encryption or reversed for decryption. Output uses a valid/ready handshake, and one start request produces exactly NCONST constants. It sits beside the round-function pipeline and replaces the fixed 7-bit, four-per-cycle free-running constant generator.

## Interface
- `W`, 7: constant/LFSR width, ≥ 2.
- `POLY`, 7'h03: feedback mask XORed in when the top bit shifts out. POLY[0] must be 1; otherwise the step is not invertible and elaboration fails.
- `SEED`, 7'h01: constant index 0, must be nonzero.
- `LANES`, 4: constants emitted per beat, ≥ 1.
- `NCONST`, 40: constants per run. It must be a multiple of LANES; otherwise elaboration fails.
- `clk`  in  1  clock. All logic is on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  run request, sampled only in IDLE.
- `dir`  in  1  captured with start: 0 = forward (index 0 up), 1 = inverse (index NCONST-1 down).
- `rc`  out  LANES*W  lane j occupies bits [j*W +: W].
- `rc_valid`  out  1  rc holds a beat.
- `rc_ready`  in  1  consumer accepts the beat.
- `rc_last`  out  1  the current beat is the final beat of the run.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- The one-step functions are defined as follows.
  - Forward: nxt = {c[W-2:0],1'b0} ^ (c[W-1] ? POLY : 0).
  - Inverse: prv = c[0] ? (((c ^ POLY) >> 1) | 1<<(W-1)) : (c >> 1).
- FSM has two states, IDLE and RUN.
  - IDLE → RUN on start. On that edge, dir is latched, the beat counter is cleared, and the state register is loaded. Forward loads SEED. Inverse loads END_C, the index-NCONST-1 value, computed at elaboration by a constant function.
  - RUN → IDLE on a handshake (rc_valid & rc_ready) while the counter equals NBEATS-1, where NBEATS = NCONST/LANES.
- In RUN, each lane is derived from the state register s:
  - Forward: lane j = fwd^j(s).
  - Inverse: lane j = inv^j(s).
  - Each lane is a combinational chain from s; nothing is registered per lane.
- On each handshake:
  - s advances LANES steps in the latched direction.
  - The counter increments.
  - Forward beat b carries indices b·LANES+j.
  - Inverse beat b carries indices NCONST-1-(b·LANES+j).
- Beat counter width is $clog2(NBEATS), with a minimum of 1. It never wraps within a run.
- Combinational outputs:
  - rc_valid = busy.
  - rc = 0 whenever rc_valid = 0.
  - rc_last = busy & (count == NBEATS-1).

## Timing
- Reset values:
  - state IDLE, s = SEED, counter 0, dir 0.
  - rc = 0, rc_valid 0, rc_last 0, busy 0, done 0.
- Latency: start in cycle t puts the first beat on rc with rc_valid = 1 in cycle t+1.
- Throughput is one beat per cycle while rc_ready is held high. A run takes NBEATS cycles plus the start cycle.
- Backpressure: while rc_valid = 1 and rc_ready = 0, rc, rc_last and s hold stable.
- done is high for the single cycle after the final handshake. busy and rc_valid are already 0 in that cycle.
- start is ignored in RUN, including the cycle of the final handshake. It is honoured in the done cycle, so back-to-back runs have exactly one idle cycle between them.
- dir is ignored except when start is accepted.
- rst takes priority over every other event. rst mid-run aborts the run: IDLE next cycle, no done pulse, reset values restored.
- The sequence period is 2^W-1 when POLY is primitive. NCONST may exceed the period; the sequence then repeats.

## Structure
- Package `rcon_pkg` holds:
  - the state enum (IDLE, RUN);
  - functions `lfsr_fwd(c, poly)` and `lfsr_inv(c, poly)`;
  - constant function `lfsr_jump(seed, poly, n)`, used to compute END_C.
- Sub-module `rcon_step` is the combinational single step with a `dir` select, W wide.
  - A chain of LANES instances produces the lanes.
  - Instance LANES provides the next s.

## Test plan
- Defaults, forward, rc_ready = 1:
  - beat 0 = {01,02,04,08} (lane 0 first), beat 1 = {10,20,40,03}, beat 2 = {06,0C,18,30};
  - rc_last on beat 9 only;
  - done one cycle after beat 9; ten beats total.
- Defaults, inverse: beat 0 lanes equal forward indices 39, 38, 37, 36 per the model; beat 9 = {08,04,02,01}.
- Backpressure:
  - hold rc_ready = 0 for 3 cycles on beat 1: rc stays {10,20,40,03};
  - raise it: beat 2 follows next cycle, with no skipped or duplicated constants.
- Start ignored and back-to-back:
  - pulse start mid-run: no effect;
  - pulse start in the done cycle: new run begins, first beat next cycle.
- Reset mid-run: assert rst during beat 4. Next cycle all outputs are at reset values and no done pulse occurs. A new start reproduces beat 0 = {01,02,04,08}.
- Parameter sweep W=8, POLY=8'h1D, LANES ∈ {1,3,5}, NCONST=15, random rc_ready:
  - the forward stream matches the model;
  - the inverse stream is its exact reversal.
